mux_rr_sched: RTL and testbench
===============================

// Module: mux_rr_sched
// PURPOSE
// Round-robin scheduler that drives the select of the 8-input, 8-bit output multiplexer.
// It shares the single mux output between eight requesting channels N1..N8 (index 0..7).
// It presents the chosen channel downstream with a valid/ready handshake.
// It grants each channel for up to BURST beats, then rotates fairly to the next eligible channel.
// PARAMETERS
// NCH    8  number of channels; fixed at 8 because sel is 3 bits wide.
// BURST  4  maximum handshakes per grant; legal range 1..255.
// CNT_W  8  width of the beat counter; must satisfy 2**CNT_W > BURST-1.
// PORTS
// clk        in   1  single clock; all state updates on the rising edge.
// rst_n      in   1  reset, asynchronous, active-low.
// req        in   8  per-channel request; req[i] means channel i has data.
// chan_en    in   8  per-channel enable mask; eligible = req & chan_en.
// ready      in   1  downstream accepts the current beat.
// sel        out  3  mux select; index of the granted channel.
// valid      out  1  mux output S is valid for channel sel.
// grant      out  8  one-hot copy of sel while valid; all zero otherwise.
// beat_last  out  1  valid && beat_cnt==BURST-1, i.e. the current beat ends the grant.
// BEHAVIOUR
// Reset (async assert; release sync to clk):
//   sel=0, valid=0, grant=0, beat_cnt=0, ptr=0, state=IDLE.
//   With ptr=0, channel 0 has first priority after reset.
// Arbitration: winner = first i with eligible[i]=1, searching ptr, ptr+1, ... mod 8.
// Handshake: hs = valid && ready. sel, grant and valid are registered outputs; no combinational path from req/ready to them.
// FSM states:
//   IDLE:
//     - valid=0.
//     - If |eligible: load sel=winner (from ptr), set beat_cnt=0, go to SERVE.
//     - Latency: req seen at edge t gives valid=1 after edge t+1.
//   SERVE:
//     - valid=1.
//     - sel is held stable while !hs, unless the grant is withdrawn.
//     - end_grant = (hs && beat_cnt==BURST-1) || !eligible[sel].
//     - If !end_grant and hs: beat_cnt+1.
//     - If end_grant:
//       - ptr <= sel+1 (mod 8); search from sel+1 for the next winner.
//       - If a winner exists: load sel=winner, beat_cnt=0, stay in SERVE. This is a back-to-back grant with no bubble.
//       - Otherwise: go to IDLE and valid=0 next cycle.
// Withdrawal: if req[sel] or chan_en[sel] drops while valid, the beat is abandoned without a handshake.
//   - valid or sel changes at the next edge.
//   - A handshake in that same cycle still counts.
// Fairness: the same channel can be re-granted consecutively only if it is the only eligible one.
//   In that case beat_cnt restarts at 0.
// BURST=1: every handshake ends the grant, so the grant rotates on every beat.
// Wrap-around: search and ptr wrap 7->0; sel+1 from 7 gives 0.
// Simultaneous events:
//   - If req rises on a channel in the same cycle as end_grant, it is eligible in that cycle's search.
//   - A chan_en change takes effect the same cycle for eligibility.
// Reset mid-grant: outputs return to reset values immediately; no beat completes.
// STRUCTURE
// Package mux_sched_pkg holds:
//   - NCH=8 and SEL_W=3.
//   - state enum {IDLE, SERVE}.
//   - function onehot8(sel) producing grant.
// Sub-module rr_pick8 (combinational):
//   - inputs: eligible[7:0], start[2:0].
//   - outputs: found, idx[2:0].
//   - rotates eligible right by start, priority-encodes, and adds start back (mod 8).
//   - Instantiated twice: start=ptr in IDLE, start=sel+1 at end of grant.
// Top-level: FSM register, sel/beat_cnt/ptr registers, output decode.
// TESTING
// 1. Reset: rst_n=0 mid-run with req=8'hFF -> sel=0, valid=0, grant=0 asynchronously.
//    After release, req=8'h01 -> valid=1, sel=0, grant=8'h01 one cycle later.
// 2. Rotation: req=8'h05, chan_en=8'hFF, ready=1, BURST=4:
//    - sel=0 for 4 beats (beat_last on 4th), then sel=2 for 4 beats, then sel=0.
//    - No idle cycle between grants.
// 3. Backpressure: ready=0 for 5 cycles while sel=3 valid.
//    - sel, valid and grant stay constant and beat_cnt stays 0.
//    - ready=1 then gives 4 handshakes before rotating.
// 4. Withdrawal: sel=5 after 1 handshake, req[5] drops with ready=0.
//    - Next cycle sel=6 if req[6]=1; otherwise valid=0 and state=IDLE.
//    - ptr=6 in both cases.
// 5. Wrap and mask: req=8'h81, chan_en=8'h7F.
//    - Only channel 0 is served, re-granted back-to-back every 4 beats.
//    - Setting chan_en=8'hFF at end of grant makes sel=7 next, then sel=0.
// 6. BURST=1 build: req=8'hFF, ready=1 -> sel steps 0,1,...,7,0 every cycle and beat_last is held at 1.

Source files
------------

// File: rtl/mux_rr_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // One-hot decode of a channel index, used for the grant vector.
    function automatic logic [NCH-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [NCH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_sched_if.sv
// Request/handshake bundle between the channels, the scheduler and the downstream mux consumer.
interface mux_rr_sched_if;
    import mux_sched_pkg::*;

    logic [NCH-1:0]   req;
    logic [NCH-1:0]   chan_en;
    logic             ready;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic [NCH-1:0]   grant;
    logic             beat_last;

    // Drives requests/ready and observes the schedule.
    modport master (
        output req, chan_en, ready,
        input  sel, valid, grant, beat_last
    );

    // The scheduler itself.
    modport slave (
        input  req, chan_en, ready,
        output sel, valid, grant, beat_last
    );

endinterface

// File: rtl/mux_rr_sched_rr_pick8.sv
// Combinational round-robin picker: first eligible channel at or after i_start, wrapping 7->0.
module rr_pick8
    import mux_sched_pkg::*;
(
    input  logic [NCH-1:0]   i_eligible,
    input  logic [SEL_W-1:0] i_start,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    logic [NCH-1:0]   w_rot;
    logic [SEL_W-1:0] w_off;

    // Rotate right by i_start so bit 0 is the highest-priority candidate; index math wraps in 3 bits.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_rot[i] = i_eligible[i_start + SEL_W'(i)];
        end
    end

    // Priority-encode the lowest set bit of the rotated vector (scan high to low, last hit wins).
    always_comb begin
        w_off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    assign o_found = |i_eligible;
    assign o_idx   = i_start + w_off;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for the 8:1 byte mux: grants a channel for up to BURST handshakes,
// then rotates to the next eligible channel with no idle bubble between grants.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int BURST = 4,   // 1..255 handshakes per grant
    parameter int CNT_W = 8    // 2**CNT_W > BURST-1
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_rr_sched_if.slave s_bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

    logic [NCH-1:0]   w_eligible;
    logic [SEL_W-1:0] w_sel_inc;
    logic             w_valid;
    logic             w_hs;
    logic             w_last;
    logic             w_end_grant;
    logic             w_idle_found, w_next_found;
    logic [SEL_W-1:0] w_idle_idx, w_next_idx;

    assign w_eligible  = s_bus.req & s_bus.chan_en;
    assign w_valid     = (r_state == SERVE);
    assign w_sel_inc   = r_sel + SEL_W'(1);
    assign w_hs        = w_valid && s_bus.ready;
    assign w_last      = (r_beat_cnt == LAST_BEAT);
    // A grant ends on its final handshake, or immediately when the served channel stops being eligible.
    assign w_end_grant = w_valid && ((w_hs && w_last) || !w_eligible[r_sel]);

    // Winner for a fresh grant out of IDLE: search from the rotation pointer.
    rr_pick8 u_pick_idle (
        .i_eligible (w_eligible),
        .i_start    (r_ptr),
        .o_found    (w_idle_found),
        .o_idx      (w_idle_idx)
    );

    // Winner for a back-to-back grant: search from the channel after the one just served.
    rr_pick8 u_pick_next (
        .i_eligible (w_eligible),
        .i_start    (w_sel_inc),
        .o_found    (w_next_found),
        .o_idx      (w_next_idx)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: enter SERVE on any eligible request, leave only when a grant ends with no successor.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_idle_found)                 w_state_nxt = SERVE;
            SERVE:   if (w_end_grant && !w_next_found) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for select, rotation pointer and beat counter.
    always_comb begin
        w_sel_nxt      = r_sel;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_idle_found) begin
                    w_sel_nxt      = w_idle_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            SERVE: begin
                if (w_end_grant) begin
                    w_ptr_nxt = w_sel_inc;
                    if (w_next_found) begin
                        w_sel_nxt      = w_next_idx;
                        w_beat_cnt_nxt = '0;
                    end
                end else if (w_hs) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Select, pointer and beat-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Output decode, purely from registered state.
    always_comb begin
        s_bus.valid     = w_valid;
        s_bus.sel       = r_sel;
        s_bus.grant     = w_valid ? onehot8(r_sel) : '0;
        s_bus.beat_last = w_valid && w_last;
    end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: table-driven rotation, directed corner sequences,
// a BURST=1 instance, and randomized traffic against a behavioural round-robin model.
module tb_mux_rr_sched;

    localparam int BURST = 4;

    logic clk;
    logic rst_n;

    mux_rr_sched_if bus0 ();
    mux_rr_sched_if bus1 ();

    mux_rr_sched #(.BURST(BURST), .CNT_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus0)
    );

    mux_rr_sched #(.BURST(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of dut0: the grant holder, beats completed in this grant, rotation pointer.
    bit m_valid;
    int m_sel;
    int m_cnt;
    int m_ptr;

    function automatic int search(input logic [7:0] el, input int start);
        for (int k = 0; k < 8; k++) begin
            if (el[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_sel = 0; m_cnt = 0; m_ptr = 0;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic [7:0] e, input logic rdy);
        logic [7:0] el;
        int w;
        int done;
        el = r & e;
        if (!m_valid) begin
            w = search(el, m_ptr);
            if (w >= 0) begin
                m_valid = 1; m_sel = w; m_cnt = 0;
            end
        end else begin
            done = m_cnt + (rdy ? 1 : 0);
            if ((rdy && done == BURST) || !el[m_sel]) begin
                m_ptr = (m_sel + 1) % 8;
                w = search(el, m_ptr);
                if (w >= 0) begin
                    m_sel = w; m_cnt = 0;
                end else begin
                    m_valid = 0;
                end
            end else begin
                m_cnt = done;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [7:0] g;
        g = 8'h01 << m_sel;
        check({tag, ".valid"}, 32'(bus0.valid), 32'(m_valid));
        check({tag, ".grant"}, 32'(bus0.grant), m_valid ? 32'(g) : 32'd0);
        check({tag, ".last"},  32'(bus0.beat_last), 32'(m_valid && (m_cnt == BURST - 1)));
        if (m_valid) check({tag, ".sel"}, 32'(bus0.sel), 32'(m_sel));
    endtask

    // Apply one cycle of inputs to dut0, advance the model, and compare just after the edge.
    task automatic step(input string tag, input logic [7:0] r, input logic [7:0] e, input logic rdy);
        bus0.req = r; bus0.chan_en = e; bus0.ready = rdy;
        @(posedge clk);
        model_edge(r, e, rdy);
        #1;
        compare_model(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus0.req = '0; bus0.chan_en = 8'hFF; bus0.ready = 1'b0;
        bus1.req = '0; bus1.chan_en = 8'hFF; bus1.ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic [7:0] en;
        logic       rdy;
        logic       exp_valid;
        logic [2:0] exp_sel;
        logic       exp_last;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [7:0] r_req;
        logic [7:0] r_en;
        logic [7:0] g;

        // Rotation with req=8'h05: four beats on 0, four on 2, back to 0 with no idle cycle.
        vecs[0] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[1] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[2] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[3] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b1};
        vecs[4] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[5] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[6] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[7] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd2, 1'b1};
        vecs[8] = '{8'h05, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b0};

        apply_reset();
        check("reset.valid", 32'(bus0.valid), 32'd0);
        check("reset.sel",   32'(bus0.sel),   32'd0);
        check("reset.grant", 32'(bus0.grant), 32'd0);

        // Table-driven rotation.
        for (int i = 0; i < 9; i++) begin
            bus0.req = vecs[i].req; bus0.chan_en = vecs[i].en; bus0.ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            g = 8'h01 << vecs[i].exp_sel;
            check($sformatf("rot[%0d].valid", i), 32'(bus0.valid),     32'(vecs[i].exp_valid));
            check($sformatf("rot[%0d].sel", i),   32'(bus0.sel),       32'(vecs[i].exp_sel));
            check($sformatf("rot[%0d].grant", i), 32'(bus0.grant),     32'(g));
            check($sformatf("rot[%0d].last", i),  32'(bus0.beat_last), 32'(vecs[i].exp_last));
        end

        // Asynchronous reset mid-grant, then one-cycle latency after release.
        apply_reset();
        step("pre_rst", 8'hFF, 8'hFF, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst.valid", 32'(bus0.valid), 32'd0);
        check("async_rst.sel",   32'(bus0.sel),   32'd0);
        check("async_rst.grant", 32'(bus0.grant), 32'd0);
        bus0.req = 8'h01;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 8'h01, 8'hFF, 1'b0);
        check("post_rst.grant01", 32'(bus0.grant), 32'h01);

        // Backpressure on channel 3: nothing moves for 5 cycles, then 4 handshakes and a re-grant.
        apply_reset();
        step("bp_load", 8'h08, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("bp_hold", 8'h08, 8'hFF, 1'b0);
            check("bp_hold.sel3", 32'(bus0.sel), 32'd3);
            check("bp_hold.nolast", 32'(bus0.beat_last), 32'd0);
        end
        for (int i = 0; i < 4; i++) step("bp_run", 8'h08, 8'hFF, 1'b1);

        // Withdrawal of channel 5 with channel 6 waiting.
        apply_reset();
        step("wd_load", 8'h60, 8'hFF, 1'b0);
        step("wd_hs",   8'h60, 8'hFF, 1'b1);
        step("wd_drop", 8'h40, 8'hFF, 1'b0);
        check("wd.sel6", 32'(bus0.sel), 32'd6);
        // Withdrawal of channel 5 with nobody waiting: drop to IDLE, pointer lands on 6.
        apply_reset();
        step("wd2_load", 8'h20, 8'hFF, 1'b0);
        step("wd2_hs",   8'h20, 8'hFF, 1'b1);
        step("wd2_drop", 8'h00, 8'hFF, 1'b0);
        check("wd2.idle", 32'(bus0.valid), 32'd0);
        step("wd2_ptr", 8'hFF, 8'hFF, 1'b0);
        check("wd2.ptr6", 32'(bus0.sel), 32'd6);

        // Wrap and mask: channel 7 masked, 0 re-granted; unmasking at end of grant picks 7 then 0.
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            step("wm_mask", 8'h81, 8'h7F, 1'b1);
            check("wm_mask.sel0", 32'(bus0.sel), 32'd0);
        end
        check("wm.end_of_grant", 32'(bus0.beat_last), 32'd1);
        step("wm_unmask", 8'h81, 8'hFF, 1'b1);
        check("wm.sel7", 32'(bus0.sel), 32'd7);
        for (int i = 0; i < 4; i++) step("wm_run", 8'h81, 8'hFF, 1'b1);
        check("wm.wrap_sel0", 32'(bus0.sel), 32'd0);

        // BURST=1 instance: rotates every beat with beat_last always high.
        apply_reset();
        bus1.req = 8'hFF; bus1.chan_en = 8'hFF; bus1.ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b1[%0d].valid", k), 32'(bus1.valid),     32'd1);
            check($sformatf("b1[%0d].sel", k),   32'(bus1.sel),       32'(k % 8));
            check($sformatf("b1[%0d].last", k),  32'(bus1.beat_last), 32'd1);
        end
        bus1.req = '0;

        // Randomized traffic against the model.
        apply_reset();
        r_req = 8'h00;
        r_en  = 8'hFF;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r_req = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r_en  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            step("rand", r_req, r_en, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
